// File: rtl/downscale_scheduler.sv
// Bilinear downscale sequencer: walks the destination grid in raster order,
// issues one interpolation job per pixel and writes results back by tag.
module downscale_scheduler #(
    parameter int SRC_H   = 32,
    parameter int SRC_W   = 32,
    parameter int DST_H   = 16,
    parameter int DST_W   = 16,
    parameter int FRAC    = 8,
    parameter int MAX_OUT = 4,
    localparam int XW     = $clog2(SRC_W),
    localparam int YW     = $clog2(SRC_H),
    localparam int TW     = $clog2(DST_H * DST_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   x_ratio,
    input  logic [15:0]   y_ratio,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          job_valid,
    input  logic          job_ready,
    output logic [XW-1:0] job_x_l,
    output logic [XW-1:0] job_x_h,
    output logic [YW-1:0] job_y_l,
    output logic [YW-1:0] job_y_h,
    output logic [FRAC-1:0] job_xw,
    output logic [FRAC-1:0] job_yw,
    output logic [TW-1:0] job_tag,
    input  logic          res_valid,
    input  logic [TW-1:0] res_tag,
    input  logic [7:0]    res_pixel,
    output logic          wr_en,
    output logic [TW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

    localparam int JW  = $clog2(DST_W);
    localparam int IW  = $clog2(DST_H);
    localparam int AXW = 16 + JW;
    localparam int AYW = 16 + IW;
    localparam int XIW = AXW - FRAC;
    localparam int YIW = AYW - FRAC;
    localparam int OW  = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t         state, state_d;
    logic [15:0]    x_r, y_r;
    logic [JW-1:0]  j;
    logic [IW-1:0]  i;
    logic [AXW-1:0] xs;
    logic [AYW-1:0] ys;
    logic [TW-1:0]  tag;
    logic [OW-1:0]  outst, outst_d;
    logic [XIW-1:0] x_ip;
    logic [YIW-1:0] y_ip;
    logic           xfer, last, start_ok, res_ok, res_spur, job_valid_d;

    assign start_ok = (state == IDLE) && start;
    assign xfer     = job_valid && job_ready;
    assign last     = (i == IW'(DST_H - 1)) && (j == JW'(DST_W - 1));
    assign res_ok   = res_valid && (outst != '0);
    assign res_spur = res_valid && (outst == '0);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign job_tag  = tag;
    assign x_ip     = xs[AXW-1:FRAC];
    assign y_ip     = ys[AYW-1:FRAC];

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (xfer && last) state_d = DRAIN;
            DRAIN:   if (outst == '0 && !wr_en) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outst_d = outst;
        if (start_ok)
            outst_d = '0;
        else
            outst_d = outst + OW'(xfer) - OW'(res_ok);
    end

    // job_valid is computed from next-cycle count so it is never high at MAX_OUT
    assign job_valid_d = (state_d == ISSUE) && (outst_d != OW'(MAX_OUT));

    always_comb begin
        job_x_l = x_ip[XW-1:0];
        job_xw  = xs[FRAC-1:0];
        job_x_h = job_x_l;
        if (x_ip > XIW'(SRC_W - 1)) begin
            job_x_l = XW'(SRC_W - 1);
            job_x_h = XW'(SRC_W - 1);
            job_xw  = '0;
        end else if (job_xw != '0 && job_x_l != XW'(SRC_W - 1)) begin
            job_x_h = job_x_l + 1'b1;
        end
    end

    always_comb begin
        job_y_l = y_ip[YW-1:0];
        job_yw  = ys[FRAC-1:0];
        job_y_h = job_y_l;
        if (y_ip > YIW'(SRC_H - 1)) begin
            job_y_l = YW'(SRC_H - 1);
            job_y_h = YW'(SRC_H - 1);
            job_yw  = '0;
        end else if (job_yw != '0 && job_y_l != YW'(SRC_H - 1)) begin
            job_y_h = job_y_l + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            x_r       <= '0;
            y_r       <= '0;
            i         <= '0;
            j         <= '0;
            xs        <= '0;
            ys        <= '0;
            tag       <= '0;
            outst     <= '0;
            job_valid <= 1'b0;
            err       <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_d;
            outst     <= outst_d;
            job_valid <= job_valid_d;
            wr_en     <= res_ok;
            if (res_ok) begin
                wr_addr <= res_tag;
                wr_data <= res_pixel;
            end
            if (start_ok) begin
                x_r <= x_ratio;
                y_r <= y_ratio;
                i   <= '0;
                j   <= '0;
                xs  <= '0;
                ys  <= '0;
                tag <= '0;
                err <= res_spur;
            end else begin
                if (res_spur)
                    err <= 1'b1;
                if (xfer) begin
                    tag <= tag + 1'b1;
                    if (j == JW'(DST_W - 1)) begin
                        j  <= '0;
                        xs <= '0;
                        i  <= i + 1'b1;
                        ys <= ys + AYW'(y_r);
                    end else begin
                        j  <= j + 1'b1;
                        xs <= xs + AXW'(x_r);
                    end
                end
            end
        end
    end

endmodule
